// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool frame reader.
// Holds the default fixed-point pixel format, the pixel typedef, the
// frame counter width and the reader FSM state encoding.
package pool_pkg;

   localparam int unsigned INTEGER_BITS_DEF     = 9;
   localparam int unsigned FIXED_POINT_BITS_DEF = 4;
   localparam int unsigned PIXEL_W              = INTEGER_BITS_DEF + FIXED_POINT_BITS_DEF;
   localparam int unsigned CNT_W                = 9;

   typedef logic signed [PIXEL_W-1:0] pixel_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TOP,
      ST_BOT,
      ST_DROP,
      ST_FLUSH
   } state_e;

endpackage

// File: rtl/maxpool_2x2_reader_if.sv
// Handshake bundle of the 2x2 max-pool reader.
// slave  : seen by the pooling block (frame control, pixel in, result out).
// master : seen by the driver of the block (testbench or upstream logic).
interface maxpool_2x2_reader_if
   import pool_pkg::*;
#(
   parameter int unsigned DW = PIXEL_W
);
   logic                 i_start;
   logic [CNT_W-1:0]     i_cols;
   logic [CNT_W-1:0]     i_rows;
   logic signed [DW-1:0] i_data;
   logic                 i_data_valid;
   logic                 o_in_ready;
   logic signed [DW-1:0] o_data;
   logic                 o_data_valid;
   logic                 i_out_ready;
   logic                 o_busy;
   logic                 o_done;

   modport slave (
      input  i_start, i_cols, i_rows, i_data, i_data_valid, i_out_ready,
      output o_in_ready, o_data, o_data_valid, o_busy, o_done
   );

   modport master (
      output i_start, i_cols, i_rows, i_data, i_data_valid, i_out_ready,
      input  o_in_ready, o_data, o_data_valid, o_busy, o_done
   );
endinterface

// File: rtl/pool_max2.sv
// Signed two-input maximum, purely combinational.
// Ports: a, b  operands (two's complement, W bits)
//        max_c larger of a and b (either one on a tie)
module pool_max2 #(
   parameter int unsigned W = 13
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] max_c
);
   assign max_c = (a >= b) ? a : b;
endmodule

// File: rtl/maxpool_2x2_reader.sv
// 2x2 max-pool over a row-major pixel stream.
// Even rows are parked in a row buffer; odd rows are compared against it and
// every second column produces one pooled result in a held output register.
// Odd trailing columns and an odd trailing row are consumed and discarded.
// Ports: i_clk clock, i_rst synchronous active-high reset,
//        bus   maxpool_2x2_reader_if.slave (frame start/size, pixel in,
//              pooled result out with valid/ready, busy, done pulse)
// Build option: MAXPOOL_RELU_EN clamps negative pooled results to 0.
module maxpool_2x2_reader
   import pool_pkg::*;
#(
   parameter int unsigned INTEGER_BITS     = INTEGER_BITS_DEF,
   parameter int unsigned FIXED_POINT_BITS = FIXED_POINT_BITS_DEF,
   parameter int unsigned MAX_COLS         = 511
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   maxpool_2x2_reader_if.slave  bus
);
   localparam int unsigned DW    = INTEGER_BITS + FIXED_POINT_BITS;
   localparam int unsigned DEPTH = MAX_COLS + 1;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e               state, state_n;
   logic [CNT_W-1:0]     col, col_n, row, row_n, cols_q, rows_q, rem_c;
   logic signed [DW-1:0] rowbuf [DEPTH];
   logic signed [DW-1:0] buf_rd_c, pair_c, mq_c, quad_c, res_c, m_q, out_q;
   logic                 out_v, done_q, busy_q;
   logic                 in_ready_c, beat_c, last_col_c;
   logic                 wr_buf_c, upd_m_c, load_c, latch_c, done_n;

   assign in_ready_c = ((state == ST_TOP) || (state == ST_BOT) || (state == ST_DROP))
                       && (!out_v || bus.i_out_ready);
   assign beat_c     = bus.i_data_valid && in_ready_c;
   assign last_col_c = (col == cols_q - CNT_W'(1));
   // Rows still to come after the current (odd) row.
   assign rem_c      = rows_q - row - CNT_W'(1);
   assign buf_rd_c   = rowbuf[AW'(col)];

   // Even column: partial max of the upper/lower pixel pair.
   pool_max2 #(.W(DW)) u_pair (.a(buf_rd_c), .b(bus.i_data), .max_c(pair_c));
   // Odd column: fold stored partial max with both pixels of this column.
   pool_max2 #(.W(DW)) u_mq   (.a(m_q),      .b(buf_rd_c),   .max_c(mq_c));
   pool_max2 #(.W(DW)) u_quad (.a(mq_c),     .b(bus.i_data), .max_c(quad_c));

`ifdef MAXPOOL_RELU_EN
   assign res_c = quad_c[DW-1] ? '0 : quad_c;
`else
   assign res_c = quad_c;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_n;
   end

   // Next state, counter updates and datapath strobes.
   always_comb begin
      state_n  = state;
      col_n    = col;
      row_n    = row;
      wr_buf_c = 1'b0;
      upd_m_c  = 1'b0;
      load_c   = 1'b0;
      latch_c  = 1'b0;
      done_n   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.i_start) begin
               if ((bus.i_cols >= CNT_W'(2)) && (bus.i_rows >= CNT_W'(2))) begin
                  state_n = ST_TOP;
                  latch_c = 1'b1;
                  col_n   = '0;
                  row_n   = '0;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         ST_TOP: begin
            if (beat_c) begin
               wr_buf_c = 1'b1;
               if (last_col_c) begin
                  col_n   = '0;
                  row_n   = row + CNT_W'(1);
                  state_n = ST_BOT;
               end else begin
                  col_n = col + CNT_W'(1);
               end
            end
         end
         ST_BOT: begin
            if (beat_c) begin
               load_c  = col[0];
               upd_m_c = !col[0];
               if (last_col_c) begin
                  col_n = '0;
                  row_n = row + CNT_W'(1);
                  if (rem_c >= CNT_W'(2))      state_n = ST_TOP;
                  else if (rem_c == CNT_W'(1)) state_n = ST_DROP;
                  else                         state_n = ST_FLUSH;
               end else begin
                  col_n = col + CNT_W'(1);
               end
            end
         end
         ST_DROP: begin
            if (beat_c) begin
               if (last_col_c) begin
                  col_n   = '0;
                  row_n   = row + CNT_W'(1);
                  state_n = ST_FLUSH;
               end else begin
                  col_n = col + CNT_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (!out_v) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Counters, frame size, partial max and output register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col    <= '0;
         row    <= '0;
         cols_q <= '0;
         rows_q <= '0;
         m_q    <= '0;
         out_q  <= '0;
         out_v  <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         col    <= col_n;
         row    <= row_n;
         done_q <= done_n;
         busy_q <= (state_n != ST_IDLE);
         if (latch_c) begin
            cols_q <= bus.i_cols;
            rows_q <= bus.i_rows;
         end
         if (upd_m_c) m_q <= pair_c;
         // A new load wins over an acceptance so back-to-back results have no bubble.
         if (load_c) begin
            out_q <= res_c;
            out_v <= 1'b1;
         end else if (out_v && bus.i_out_ready) begin
            out_v <= 1'b0;
         end
      end
   end

   // Row buffer holds the even row; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (wr_buf_c) rowbuf[AW'(col)] <= bus.i_data;
   end

   assign bus.o_in_ready   = in_ready_c;
   assign bus.o_data       = out_q;
   assign bus.o_data_valid = out_v;
   assign bus.o_busy       = busy_q;
   assign bus.o_done       = done_q;
endmodule

// File: tb/tb_maxpool_2x2_reader.sv
// Directed bench for maxpool_2x2_reader: reset state, 4x4 and 5x3 frames,
// output backpressure, degenerate frame size and mid-frame reset.
// Honours MAXPOOL_RELU_EN for the negative-pixel frame.
module tb_maxpool_2x2_reader;
   import pool_pkg::*;

   localparam int DW = 13;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   maxpool_2x2_reader_if #(.DW(DW)) bus ();

   maxpool_2x2_reader #(
      .INTEGER_BITS(9), .FIXED_POINT_BITS(4), .MAX_COLS(511)
   ) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   logic signed [DW-1:0] pix [64];
   logic signed [DW-1:0] outq [$];
   int   n_acc, done_cnt, first_valid_cyc;
   int   beat_cyc [64];
   logic busy_first;

   task automatic start_frame(input int c, input int r);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_cols  = 9'(c);
      bus.i_rows  = 9'(r);
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   // Feed n pixels from pix[] for budget cycles, collecting results and done pulses.
   task automatic stream(input int n, input int budget);
      int idx = 0;
      outq.delete();
      done_cnt        = 0;
      first_valid_cyc = -1;
      busy_first      = 1'b0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         bus.i_data_valid = (idx < n);
         bus.i_data       = (idx < n) ? pix[idx] : '0;
         #1;
         if (cyc == 0) busy_first = bus.o_busy;
         if (bus.o_data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.o_data_valid && bus.i_out_ready) outq.push_back(bus.o_data);
         if (bus.o_done) done_cnt++;
         if (bus.i_data_valid && bus.o_in_ready) begin
            beat_cyc[idx] = cyc;
            idx++;
         end
      end
      n_acc = idx;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      total++; if (bus.o_data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.o_data_valid); end
      total++; if (bus.o_data !== '0)         begin bad++; $display("FAIL rst_data got=%0d exp=0", bus.o_data); end
      total++; if (bus.o_done !== 1'b0)       begin bad++; $display("FAIL rst_done got=%b exp=0", bus.o_done); end
      total++; if (bus.o_busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
      total++; if (bus.o_in_ready !== 1'b0)   begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.o_in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_4x4();
      int exp [4] = '{5, 7, 13, 15};
      logic signed [DW-1:0] got;
      for (int i = 0; i < 16; i++) pix[i] = DW'(i);
      start_frame(4, 4);
      stream(16, 30);
      total++; if (outq.size() != 4) begin bad++; $display("FAIL f4x4_count got=%0d exp=4", outq.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < outq.size()) ? outq[i] : 'x;
         total++; if (got !== DW'(exp[i])) begin bad++; $display("FAIL f4x4_out%0d got=%0d exp=%0d", i, got, exp[i]); end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL f4x4_done got=%0d exp=1", done_cnt); end
      total++; if (n_acc != 16)   begin bad++; $display("FAIL f4x4_accepted got=%0d exp=16", n_acc); end
      total++; if (first_valid_cyc != beat_cyc[5] + 1) begin
         bad++; $display("FAIL f4x4_latency got=%0d exp=%0d", first_valid_cyc, beat_cyc[5] + 1);
      end
      total++; if (busy_first !== 1'b1) begin bad++; $display("FAIL f4x4_busy got=%b exp=1", busy_first); end
      total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL f4x4_idle_busy got=%b exp=0", bus.o_busy); end
   endtask

   task automatic test_odd_frame();
      int exp [2];
      logic signed [DW-1:0] got;
`ifdef MAXPOOL_RELU_EN
      exp = '{0, 0};
`else
      exp = '{-1, -3};
`endif
      for (int i = 0; i < 15; i++) pix[i] = DW'(-(i + 1));
      start_frame(5, 3);
      stream(15, 30);
      total++; if (outq.size() != 2) begin bad++; $display("FAIL f5x3_count got=%0d exp=2", outq.size()); end
      for (int i = 0; i < 2; i++) begin
         got = (i < outq.size()) ? outq[i] : 'x;
         total++; if (got !== DW'(exp[i])) begin bad++; $display("FAIL f5x3_out%0d got=%0d exp=%0d", i, got, exp[i]); end
      end
      total++; if (n_acc != 15)   begin bad++; $display("FAIL f5x3_accepted got=%0d exp=15", n_acc); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL f5x3_done got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_backpressure();
      int exp [2] = '{9, 8};
      int vals [8] = '{1, 9, 2, 3, 4, 5, 8, 6};
      int idx = 0, hold_cnt = 0, stall_bad = 0, idx_hold = -1, dcnt = 0;
      logic signed [DW-1:0] got;
      for (int i = 0; i < 8; i++) pix[i] = DW'(vals[i]);
      outq.delete();
      bus.i_out_ready = 1'b0;
      start_frame(4, 2);
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         bus.i_out_ready  = (hold_cnt >= 5);
         bus.i_data_valid = (idx < 8);
         bus.i_data       = (idx < 8) ? pix[idx] : '0;
         #1;
         if (bus.o_data_valid && !bus.i_out_ready) begin
            hold_cnt++;
            idx_hold = idx;
            if (bus.o_in_ready !== 1'b0 || bus.o_data !== DW'(9)) stall_bad++;
         end
         if (bus.o_data_valid && bus.i_out_ready) outq.push_back(bus.o_data);
         if (bus.o_done) dcnt++;
         if (bus.i_data_valid && bus.o_in_ready) idx++;
      end
      total++; if (hold_cnt != 5)  begin bad++; $display("FAIL bp_hold got=%0d exp=5", hold_cnt); end
      total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_cycles got=%0d exp=0", stall_bad); end
      total++; if (idx_hold != 6)  begin bad++; $display("FAIL bp_stall_index got=%0d exp=6", idx_hold); end
      total++; if (outq.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", outq.size()); end
      for (int i = 0; i < 2; i++) begin
         got = (i < outq.size()) ? outq[i] : 'x;
         total++; if (got !== DW'(exp[i])) begin bad++; $display("FAIL bp_out%0d got=%0d exp=%0d", i, got, exp[i]); end
      end
      total++; if (idx != 8)  begin bad++; $display("FAIL bp_accepted got=%0d exp=8", idx); end
      total++; if (dcnt != 1) begin bad++; $display("FAIL bp_done got=%0d exp=1", dcnt); end
   endtask

   task automatic test_degenerate();
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_cols  = 9'd1;
      bus.i_rows  = 9'd8;
      @(negedge clk);
      bus.i_start = 1'b0;
      #1;
      total++; if (bus.o_done !== 1'b1)       begin bad++; $display("FAIL deg_done got=%b exp=1", bus.o_done); end
      total++; if (bus.o_data_valid !== 1'b0) begin bad++; $display("FAIL deg_valid got=%b exp=0", bus.o_data_valid); end
      total++; if (bus.o_busy !== 1'b0)       begin bad++; $display("FAIL deg_busy got=%b exp=0", bus.o_busy); end
      @(negedge clk); #1;
      total++; if (bus.o_done !== 1'b0)       begin bad++; $display("FAIL deg_done_clear got=%b exp=0", bus.o_done); end
      total++; if (bus.o_data_valid !== 1'b0) begin bad++; $display("FAIL deg_valid_late got=%b exp=0", bus.o_data_valid); end
   endtask

   task automatic test_mid_reset();
      int v2 [4] = '{3, -2, 7, 1};
      logic signed [DW-1:0] got;
      for (int i = 0; i < 16; i++) pix[i] = DW'(i);
      start_frame(4, 4);
      stream(6, 8);
      got = (outq.size() > 0) ? outq[0] : 'x;
      total++; if (got !== DW'(5)) begin bad++; $display("FAIL mr_pre_out got=%0d exp=5", got); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      total++; if (bus.o_data_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", bus.o_data_valid); end
      total++; if (bus.o_data !== '0)         begin bad++; $display("FAIL mr_data got=%0d exp=0", bus.o_data); end
      total++; if (bus.o_done !== 1'b0)       begin bad++; $display("FAIL mr_done got=%b exp=0", bus.o_done); end
      total++; if (bus.o_busy !== 1'b0)       begin bad++; $display("FAIL mr_busy got=%b exp=0", bus.o_busy); end
      total++; if (bus.o_in_ready !== 1'b0)   begin bad++; $display("FAIL mr_in_ready got=%b exp=0", bus.o_in_ready); end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) pix[i] = DW'(v2[i]);
      start_frame(2, 2);
      stream(4, 16);
      total++; if (outq.size() != 1) begin bad++; $display("FAIL mr_count got=%0d exp=1", outq.size()); end
      got = (outq.size() > 0) ? outq[0] : 'x;
      total++; if (got !== DW'(7))  begin bad++; $display("FAIL mr_out got=%0d exp=7", got); end
      total++; if (done_cnt != 1)   begin bad++; $display("FAIL mr_frame_done got=%0d exp=1", done_cnt); end
   endtask

   initial begin
      rst              = 1'b1;
      bus.i_start      = 1'b0;
      bus.i_cols       = '0;
      bus.i_rows       = '0;
      bus.i_data       = '0;
      bus.i_data_valid = 1'b0;
      bus.i_out_ready  = 1'b1;
      repeat (3) @(negedge clk);
      test_reset();
      test_4x4();
      test_odd_frame();
      test_backpressure();
      test_degenerate();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
